aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Parametrised round-sequencing controller for the AES datapath, the successor to the fixed AES-128 encrypt-only controller. Supports AES-128/192/256 (10/12/14 rounds), encrypt or decrypt key-index ordering, a configurable number of datapath cycles per round, synchronous abort and a valid/ready result handshake. Sits between the top-level command interface and the round datapath/key-schedule, driving the datapath input mux, key requests and the round-key index.

## Interface

- CYCLES_PER_ROUND, 3, datapath cycles spent in each MID/LAST round; legal range 1..4
- ROUND_W, 4, width of round_idx; must hold 14

- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin operation; sampled only in IDLE
- key_len  in  2  sampled with start: 0=AES-128 (Nr=10), 1=AES-192 (Nr=12), 2=AES-256 (Nr=14), 3 treated as 0
- decrypt  in  1  sampled with start: 0=encrypt key order, 1=decrypt key order
- abort  in  1  synchronous cancel; ignored in IDLE
- out_ready  in  1  consumer accepts result
- busy  out  1  high in every state except IDLE
- mux_sel  out  1  0 selects external block input (INIT), 1 selects round feedback (MID/LAST)
- req_key  out  1  request round key round_idx from key schedule
- round_idx  out  ROUND_W  current round-key index
- last_round  out  1  high throughout LAST (datapath skips MixColumns)
- out_valid  out  1  result available; held until accepted

## Operation

- States: IDLE, INIT, MID, LAST, HOLD. Registers: state, Nr (4b), dec flag, round counter r (4b), cycle counter cyc (2b).
- IDLE: all outputs 0, round_idx=0. start=1 -> latch Nr, dec; r<=0, cyc<=0; next INIT.
- INIT (1 cycle): mux_sel=0, req_key=1, r=0. Next MID, r<=1, cyc<=0.
- MID: mux_sel=1. req_key=1 only when cyc==0. When cyc==CYCLES_PER_ROUND-1: cyc<=0, r<=r+1, next LAST if r==Nr-1 else MID; otherwise cyc<=cyc+1.
- LAST: mux_sel=1, last_round=1, req_key=1 only when cyc==0. When cyc==CYCLES_PER_ROUND-1 -> HOLD; otherwise cyc<=cyc+1.
- HOLD: out_valid=1, mux_sel=0, req_key=0. out_ready=1 -> IDLE next cycle.
- round_idx = r when dec=0, Nr-r when dec=1 (INIT gives 0 or Nr; LAST gives Nr or 0).
- CYCLES_PER_ROUND=1: every MID/LAST cycle has cyc==0, so req_key high every round cycle.
- abort=1 in INIT/MID/LAST/HOLD -> IDLE next cycle, no out_valid, counters cleared; abort beats out_ready in HOLD.
- start while busy ignored (including HOLD and the out_ready-accept cycle); no queuing.
- key_len/decrypt changes while busy have no effect.

## Timing

- Reset: state IDLE, r=0, cyc=0, Nr=10, dec=0; all outputs 0 asynchronously on reset_n low. reset_n low mid-operation discards the operation with no out_valid.
- All outputs are decoded from registered state/counters only (Moore); no combinational input-to-output path.
- Latency: edge sampling start -> edge raising out_valid = 1 + Nr*CYCLES_PER_ROUND edges (AES-128/CPR=3: 31; AES-256/CPR=3: 43; AES-192/CPR=1: 13).
- req_key pulses per operation: Nr+1 (one INIT + one per round).
- Back-to-back: out_ready in HOLD -> IDLE for one cycle; earliest next start sample is that IDLE cycle, so minimum start-to-start spacing is latency+2 edges.

## Test plan

- Reset then AES-128 encrypt, CPR=3, out_ready=1: out_valid high 31 edges after start; round_idx 0,1..10; 11 req_key pulses; last_round high 3 cycles with round_idx=10; out_valid single cycle.
- AES-256 decrypt, CPR=3: round_idx 14,13..0; last_round cycles show round_idx=0; out_valid at 43 edges; key_len=3 run behaves as AES-128.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid held 6 cycles, start pulses during HOLD ignored; out_ready=1 -> IDLE next edge, busy=0.
- Abort in MID round 4, and separately abort with out_ready=1 in HOLD -> IDLE next edge, out_valid never/no longer asserted, next start runs full 31-edge sequence.
- CPR=1 build, AES-192: req_key high every cycle INIT..LAST, out_valid at edge 13.
- reset_n asserted in LAST mid-round: all outputs 0 immediately, state IDLE; key_len/decrypt toggled mid-run on a separate run have no effect on round_idx sequence.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: command and datapath-control bundle for aes_round_ctrl.
//   master : command side (start/key_len/decrypt/abort/out_ready out, status in)
//   slave  : controller side (command in, busy/mux_sel/req_key/round_idx/
//            last_round/out_valid out)
interface aes_round_ctrl_if #(
  parameter int ROUND_W = 4
);
  logic               start;
  logic [1:0]         key_len;
  logic               decrypt;
  logic               abort;
  logic               out_ready;
  logic               busy;
  logic               mux_sel;
  logic               req_key;
  logic [ROUND_W-1:0] round_idx;
  logic               last_round;
  logic               out_valid;

  modport master (
    output start, key_len, decrypt, abort, out_ready,
    input  busy, mux_sel, req_key, round_idx, last_round, out_valid
  );

  modport slave (
    input  start, key_len, decrypt, abort, out_ready,
    output busy, mux_sel, req_key, round_idx, last_round, out_valid
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: round sequencer for the AES datapath (AES-128/192/256,
// encrypt or decrypt key order, CYCLES_PER_ROUND datapath cycles per round).
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of aes_round_ctrl_if
//             in : start, key_len, decrypt, abort, out_ready
//             out: busy, mux_sel, req_key, round_idx, last_round, out_valid
//
// state  | meaning
// IDLE   | waiting for start, all outputs low
// INIT   | one cycle, external block selected, key 0 (or Nr) requested
// MID    | middle rounds 1..Nr-1, feedback selected
// LAST   | final round, MixColumns skipped
// HOLD   | result valid, waiting for out_ready
module aes_round_ctrl #(
  parameter int CYCLES_PER_ROUND = 3,
  parameter int ROUND_W          = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  aes_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_MID,
    S_LAST,
    S_HOLD
  } state_t;

  localparam logic [1:0] CYC_LAST = 2'(CYCLES_PER_ROUND - 1);

  state_t     state, state_nx;
  logic [3:0] nr, nr_nx;
  logic       dec, dec_nx;
  logic [3:0] r, r_nx;
  logic [1:0] cyc, cyc_nx;
  logic [3:0] nr_sel;
  logic [3:0] idx;

  always_comb begin
    case (bus.key_len)
      2'd1:    nr_sel = 4'd12;
      2'd2:    nr_sel = 4'd14;
      default: nr_sel = 4'd10;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      nr    <= 4'd10;
      dec   <= 1'b0;
      r     <= 4'd0;
      cyc   <= 2'd0;
    end else begin
      state <= state_nx;
      nr    <= nr_nx;
      dec   <= dec_nx;
      r     <= r_nx;
      cyc   <= cyc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    nr_nx    = nr;
    dec_nx   = dec;
    r_nx     = r;
    cyc_nx   = cyc;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nx = S_INIT;
          nr_nx    = nr_sel;
          dec_nx   = bus.decrypt;
          r_nx     = 4'd0;
          cyc_nx   = 2'd0;
        end
      end
      S_INIT: begin
        state_nx = S_MID;
        r_nx     = 4'd1;
        cyc_nx   = 2'd0;
      end
      S_MID: begin
        if (cyc == CYC_LAST) begin
          cyc_nx   = 2'd0;
          r_nx     = r + 4'd1;
          state_nx = (r == nr - 4'd1) ? S_LAST : S_MID;
        end else begin
          cyc_nx = cyc + 2'd1;
        end
      end
      S_LAST: begin
        if (cyc == CYC_LAST) begin
          state_nx = S_HOLD;
          cyc_nx   = 2'd0;
        end else begin
          cyc_nx = cyc + 2'd1;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_nx = S_IDLE;
          r_nx     = 4'd0;
          cyc_nx   = 2'd0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        r_nx     = 4'd0;
        cyc_nx   = 2'd0;
      end
    endcase
    // abort overrides everything outside IDLE, including a HOLD accept
    if (state != S_IDLE && bus.abort) begin
      state_nx = S_IDLE;
      r_nx     = 4'd0;
      cyc_nx   = 2'd0;
    end
  end

  // decrypt walks the key schedule backwards: Nr down to 0
  assign idx = dec ? (nr - r) : r;

  always_comb begin
    bus.busy       = 1'b0;
    bus.mux_sel    = 1'b0;
    bus.req_key    = 1'b0;
    bus.last_round = 1'b0;
    bus.out_valid  = 1'b0;
    bus.round_idx  = '0;
    case (state)
      S_INIT: begin
        bus.busy      = 1'b1;
        bus.req_key   = 1'b1;
        bus.round_idx = ROUND_W'(idx);
      end
      S_MID: begin
        bus.busy      = 1'b1;
        bus.mux_sel   = 1'b1;
        bus.req_key   = (cyc == 2'd0);
        bus.round_idx = ROUND_W'(idx);
      end
      S_LAST: begin
        bus.busy       = 1'b1;
        bus.mux_sel    = 1'b1;
        bus.req_key    = (cyc == 2'd0);
        bus.last_round = 1'b1;
        bus.round_idx  = ROUND_W'(idx);
      end
      S_HOLD: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.round_idx = ROUND_W'(idx);
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sel;
  logic       start;
  logic [1:0] key_len;
  logic       decrypt;
  logic       abort;
  logic       out_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int nr;
    bit dec;
    int cpr;
    int lat;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  aes_round_ctrl_if #(.ROUND_W(4)) bus_a ();
  aes_round_ctrl_if #(.ROUND_W(4)) bus_b ();

  assign bus_a.start     = start & ~sel;
  assign bus_a.abort     = abort & ~sel;
  assign bus_a.key_len   = key_len;
  assign bus_a.decrypt   = decrypt;
  assign bus_a.out_ready = out_ready;
  assign bus_b.start     = start & sel;
  assign bus_b.abort     = abort & sel;
  assign bus_b.key_len   = key_len;
  assign bus_b.decrypt   = decrypt;
  assign bus_b.out_ready = out_ready;

  aes_round_ctrl #(.CYCLES_PER_ROUND(3), .ROUND_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );
  aes_round_ctrl #(.CYCLES_PER_ROUND(1), .ROUND_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  // {busy, mux_sel, req_key, last_round, out_valid, round_idx}
  logic [8:0] obs_a, obs_b, obs;
  assign obs_a = {bus_a.busy, bus_a.mux_sel, bus_a.req_key, bus_a.last_round,
                  bus_a.out_valid, bus_a.round_idx};
  assign obs_b = {bus_b.busy, bus_b.mux_sel, bus_b.req_key, bus_b.last_round,
                  bus_b.out_valid, bus_b.round_idx};
  assign obs = sel ? obs_b : obs_a;

  task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, x);
    end
  endtask

  // expected outputs n cycles after the edge that sampled start
  function automatic logic [8:0] model(input exp_t e, input int n);
    int k, pos;
    logic [3:0] i;
    if (n == 0) begin
      i = e.dec ? 4'(e.nr) : 4'd0;
      return {5'b10100, i};
    end else if (n <= e.nr * e.cpr) begin
      k   = (n - 1) / e.cpr + 1;
      pos = (n - 1) % e.cpr;
      i   = e.dec ? 4'(e.nr - k) : 4'(k);
      return {1'b1, 1'b1, (pos == 0), (k == e.nr), 1'b0, i};
    end else begin
      return 9'b10001_0000;
    end
  endfunction

  task automatic run_op(input bit s, input logic [1:0] kl, input bit dc,
                        input int exp_lat, input int abort_at, input int hold_wait,
                        input bit hold_start, input bit toggle, input int reset_at);
    exp_t e, p;
    int n, reqs;
    bit done, accept, aborted, popped, was_reset;
    logic [8:0] x;
    e.nr  = (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
    e.dec = dc;
    e.cpr = s ? 1 : 3;
    e.lat = exp_lat;
    sel = s; key_len = kl; decrypt = dc; abort = 1'b0;
    out_ready = (hold_wait == 0);
    start = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; reqs = 0; done = 0; accept = 0; aborted = 0; popped = 0; was_reset = 0;
    while (!done) begin
      @(negedge clk);
      if (accept || aborted || was_reset) begin
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        chk("idle_after", obs, 9'd0);
        done = 1;
      end else if (n > 200) begin
        total++; bad++;
        $error("FAIL timeout observed=%0d expected<=%0d", n, exp_lat);
        done = 1;
      end else begin
        x = model(e, n);
        if (n > e.nr * e.cpr) begin
          chk("hold", {obs[8:4], 4'd0}, x);
          if (!popped) begin
            p = sbq.pop_front();
            popped = 1;
            chk_int("latency", n, p.lat);
          end
          out_ready = ((n - (e.nr * e.cpr + 1)) >= hold_wait);
          if (out_ready) accept = 1;
          start = hold_start;
        end else begin
          chk("cycle", obs, x);
          if (obs[6]) reqs++;
        end
        if (toggle) begin
          key_len = key_len + 2'd1;
          decrypt = ~decrypt;
        end
        if (n == abort_at) begin
          abort = 1'b1;
          aborted = 1;
        end
        if (n == reset_at) begin
          #2 reset_n = 1'b0;
          #1 chk("reset_async", obs, 9'd0);
          was_reset = 1;
          @(negedge clk);
          chk("reset_hold", obs, 9'd0);
          reset_n = 1'b1;
        end
        n++;
      end
    end
    if (!popped) begin
      void'(sbq.pop_front());
    end
    if (!aborted && !was_reset) chk_int("req_pulses", reqs, e.nr + 1);
    @(negedge clk);
    chk("idle_stay", obs, 9'd0);
  endtask

  initial begin
    sel = 1'b0; start = 1'b0; key_len = 2'd0; decrypt = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
    reset_n = 1'b0;
    #3;
    chk("reset_a", obs_a, 9'd0);
    chk("reset_b", obs_b, 9'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // AES-128 encrypt
    run_op(1'b0, 2'd0, 1'b0, 31, -1, 0, 1'b0, 1'b0, -1);
    // AES-256 decrypt
    run_op(1'b0, 2'd2, 1'b1, 43, -1, 0, 1'b0, 1'b0, -1);
    // key_len 3 behaves as AES-128
    run_op(1'b0, 2'd3, 1'b0, 31, -1, 0, 1'b0, 1'b0, -1);
    // backpressure: out_ready low 5 HOLD cycles, start pulses ignored
    run_op(1'b0, 2'd0, 1'b0, 31, -1, 5, 1'b1, 1'b0, -1);
    // abort in MID round 4
    run_op(1'b0, 2'd0, 1'b0, 31, 11, 0, 1'b0, 1'b0, -1);
    // abort with out_ready in HOLD
    run_op(1'b0, 2'd0, 1'b0, 31, 31, 0, 1'b0, 1'b0, -1);
    // full sequence after abort
    run_op(1'b0, 2'd0, 1'b0, 31, -1, 0, 1'b0, 1'b0, -1);
    // CPR=1 build, AES-192
    run_op(1'b1, 2'd1, 1'b0, 13, -1, 0, 1'b0, 1'b0, -1);
    // reset_n in LAST mid-round
    run_op(1'b0, 2'd0, 1'b0, 31, -1, 0, 1'b0, 1'b0, 29);
    // config toggled while busy, AES-128 decrypt
    run_op(1'b0, 2'd0, 1'b1, 31, -1, 0, 1'b0, 1'b1, -1);
    // CPR=1 AES-256 decrypt
    run_op(1'b1, 2'd2, 1'b1, 15, -1, 0, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
